// File: rtl/softmax_stream_unit.sv
// Streaming fixed-point softmax: frame captured in IDLE, then MAX/EXP/SUM/DIV passes of N_CLASSES cycles each; result held in OUT until out_ready.
// Optional argmax_idx output is enabled by defining SOFTMAX_ARGMAX_EN.
module softmax_stream_unit #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLASSES*DATA_W-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N_CLASSES*DATA_W-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [$clog2(N_CLASSES)-1:0]  argmax_idx
`endif
);

  localparam int CNT_W = $clog2(N_CLASSES);
  localparam int SUM_W = DATA_W + CNT_W;
  localparam int NUM_W = DATA_W + FRAC_W;
  localparam int DIV_W = NUM_W + SUM_W;
  localparam int ONE_I = 1 << FRAC_W;
  localparam logic signed [DATA_W:0]   ONE    = (DATA_W+1)'(ONE_I);
  localparam logic signed [DATA_W:0]   CUTOFF = (DATA_W+1)'(-2 * ONE_I);
  localparam logic signed [DATA_W-1:0] X_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAX, EXP, SUM, DIV, OUT} state_t;
  state_t state, state_nxt;

  logic [N_CLASSES*DATA_W-1:0] frame_r;
  logic [DATA_W-1:0]           e_mem [N_CLASSES];
  logic [CNT_W-1:0]            cnt;
  logic                        last;
  logic signed [DATA_W-1:0]    max_r, x_cur;
  logic [SUM_W-1:0]            sum_r;
  logic signed [DATA_W:0]      d, t;
  logic [2*DATA_W+1:0]         sq;
  logic [DATA_W-1:0]           e_cur, e_rd, q_sat;
  logic [DIV_W-1:0]            q;
`ifdef SOFTMAX_ARGMAX_EN
  logic [CNT_W-1:0]            max_idx;
`endif

  assign last      = (cnt == CNT_W'(N_CLASSES - 1));
  assign x_cur     = frame_r[cnt*DATA_W +: DATA_W];
  assign e_rd      = e_mem[cnt];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // Piecewise-quadratic exp approximation: ((1 + d/2)^2), zero below d = -2.
  always_comb begin
    d     = {x_cur[DATA_W-1], x_cur} - {max_r[DATA_W-1], max_r};
    t     = ONE + (d >>> 1);
    sq    = {{(DATA_W+1){1'b0}}, t} * {{(DATA_W+1){1'b0}}, t};
    e_cur = (d <= CUTOFF) ? '0 : DATA_W'(sq >> FRAC_W);
  end

  always_comb begin
    q = {{SUM_W{1'b0}}, e_rd, {FRAC_W{1'b0}}} / {{NUM_W{1'b0}}, sum_r};
    if (sum_r == '0)
      q_sat = '0;
    else if (|q[DIV_W-1:DATA_W])
      q_sat = '1;
    else
      q_sat = q[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MAX;
      MAX:     if (last)      state_nxt = EXP;
      EXP:     if (last)      state_nxt = SUM;
      SUM:     if (last)      state_nxt = DIV;
      DIV:     if (last)      state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_r  <= '0;
      cnt      <= '0;
      max_r    <= '0;
      sum_r    <= '0;
      out_data <= '0;
`ifdef SOFTMAX_ARGMAX_EN
      max_idx    <= '0;
      argmax_idx <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame_r <= in_data;
            cnt     <= '0;
            max_r   <= X_MIN;
            sum_r   <= '0;
`ifdef SOFTMAX_ARGMAX_EN
            max_idx <= '0;
`endif
          end
        end
        MAX: begin
          // Strictly-greater update keeps the lowest index on ties.
          if (x_cur > max_r) begin
            max_r <= x_cur;
`ifdef SOFTMAX_ARGMAX_EN
            max_idx <= cnt;
`endif
          end
          cnt <= last ? '0 : cnt + 1'b1;
        end
        EXP: cnt <= last ? '0 : cnt + 1'b1;
        SUM: begin
          sum_r <= sum_r + SUM_W'(e_rd);
          cnt   <= last ? '0 : cnt + 1'b1;
        end
        DIV: begin
          out_data[cnt*DATA_W +: DATA_W] <= q_sat;
`ifdef SOFTMAX_ARGMAX_EN
          if (last) argmax_idx <= max_idx;
`endif
          cnt <= last ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == EXP)
      e_mem[cnt] <= e_cur;
  end

endmodule

// File: doc/softmax_stream_unit.md
SOFTMAX_STREAM_UNIT -- requirements
Module: softmax_stream_unit

Interface
REQ-001 Parameter N_CLASSES, default 10, number of logits per frame (2..64).
REQ-002 Parameter DATA_W, default 16, width of each signed logit and each unsigned probability.
REQ-003 Parameter FRAC_W, default 8, fractional bits of both logits and outputs; ONE = 1<<FRAC_W.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_data  in  N_CLASSES*DATA_W  packed signed logits; element i at bits [i*DATA_W +: DATA_W].
REQ-007 in_valid  in  1  frame offered.
REQ-008 in_ready  out  1  block can accept a frame.
REQ-009 out_data  out  N_CLASSES*DATA_W  packed unsigned probabilities, same packing as in_data.
REQ-010 out_valid  out  1  out_data valid.
REQ-011 out_ready  in  1  downstream accepts result.
REQ-012 argmax_idx  out  clog2(N_CLASSES)  index of the largest logit; present only with SOFTMAX_ARGMAX_EN.

Function
REQ-013 States IDLE, MAX, EXP, SUM, DIV, OUT; in_ready = (state==IDLE).
REQ-014 On in_valid && in_ready, in_data is captured into an internal frame register, state goes to MAX; in_data is not read afterwards.
REQ-015 Each of MAX, EXP, SUM and DIV processes one element per cycle for exactly N_CLASSES cycles, moving to the next state with no idle cycle.
REQ-016 out_valid rises at the 4*N_CLASSES-th rising edge after the acceptance edge (40 for defaults).
REQ-017 MAX: running max, initialised to -2^(DATA_W-1), updated only when an element is strictly greater.
REQ-018 EXP: d = x_i - max (DATA_W+1 bits signed, d <= 0); if d <= -2*ONE then e_i = 0, else e_i = ((ONE + (d>>>1))^2) >> FRAC_W, unsigned DATA_W bits.
REQ-019 SUM: sum of e_i in DATA_W+clog2(N_CLASSES) bits, no overflow possible.
REQ-020 DIV: out_i = (e_i << FRAC_W) / sum, truncating, saturated to 2^DATA_W-1; sum==0 yields out_i = 0.
REQ-021 OUT: out_valid and out_data held stable until out_valid && out_ready; then state goes to IDLE, out_valid drops, and in_ready rises in the following cycle (no same-cycle bypass).
REQ-022 in_valid is ignored whenever state != IDLE.
REQ-023 out_data keeps its last value after the handshake until the next frame's DIV overwrites it.

Reset
REQ-024 rst forces state IDLE, out_valid 0, out_data 0, argmax_idx 0, and all counters 0.
REQ-025 rst at any point during a frame discards the frame; no out_valid pulse is produced for it.
REQ-026 in_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro SOFTMAX_ARGMAX_EN defined, argmax_idx exists and holds the index of the element that set the final MAX value (lowest index on ties); it is registered with out_data and valid with out_valid.
REQ-028 Without SOFTMAX_ARGMAX_EN, the port and its logic are absent, and all other behaviour is identical.

Verification (N_CLASSES=10, DATA_W=16, FRAC_W=8)
REQ-029 All ten logits 0x0100 -> every out_i = 0x0019, and out_valid rises exactly 40 edges after acceptance.
REQ-030 logit[3]=0x0400, all other logits 0 -> out[3]=0x0100, all others 0x0000, argmax_idx=3.
REQ-031 logit[0]=0x0100, logit[1]=0x0000, logits[2..9]=0xF800 -> out[0]=204, out[1]=51, others 0.
REQ-032 out_ready held low 5 cycles in OUT, with in_valid high throughout -> out_valid and out_data stay stable and in_ready stays 0; on the handshake the block goes to IDLE, and the pending frame is accepted on the following cycle.
REQ-033 rst pulsed during EXP -> out_valid stays 0 and in_ready=1 after reset; the next frame (as in REQ-029) produces the correct result with correct latency.
REQ-034 logit[2]=logit[7]=0x0300 (maximum), others 0 -> argmax_idx=2, and out[2]=out[7].
